// File: rtl/axi_burst_slave.sv
// axi_burst_slave
//   AXI4 slave that splits its address space into three windows:
//     CSR      : upper ADDR_W-CSR_AW address bits all zero -> single-beat
//                accesses turned into csr_wen / csr_ren strobes.
//     DMA      : top nibble == DMA_TAG -> bursts streamed straight through
//                to/from the DMA FIFOs with valid/ready pass-through.
//     UNMAPPED : everything else -> DECERR, no side effects.
//   Independent write (W_IDLE/W_DATA/W_RESP) and read
//   (R_IDLE/R_CSR/R_DMA/R_ERR) state machines.
//
// Ports
//   clk, rst                 : single clock, synchronous active-high reset
//   s_axi_aw*/w*/b*          : AXI write address / data / response channels
//   s_axi_ar*/r*             : AXI read address / data channels
//   csr_wen/waddr/wdata/wstrb: CSR write strobe (same cycle as W handshake)
//   csr_ren/raddr, csr_rdata : CSR read strobe, data returned one cycle later
//   dma_wdata/wvalid/wready  : stream into the DMA input FIFO
//   dma_rdata/rvalid/rready  : stream out of the DMA result FIFO
//   busy                     : either state machine away from idle
//   err_pulse, err_count     : per-error-response pulse, saturating counter
module axi_burst_slave #(
  parameter int         DATA_W  = 32,
  parameter int         ADDR_W  = 32,
  parameter int         CSR_AW  = 8,
  parameter logic [3:0] DMA_TAG = 4'h1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     s_axi_awaddr,
  input  logic [1:0]            s_axi_awburst,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_W-1:0]     s_axi_wdata,
  input  logic [DATA_W/8-1:0]   s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_W-1:0]     s_axi_araddr,
  input  logic [1:0]            s_axi_arburst,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [DATA_W-1:0]     s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic                  csr_wen,
  output logic [CSR_AW-1:0]     csr_waddr,
  output logic [DATA_W-1:0]     csr_wdata,
  output logic [DATA_W/8-1:0]   csr_wstrb,
  output logic                  csr_ren,
  output logic [CSR_AW-1:0]     csr_raddr,
  input  logic [DATA_W-1:0]     csr_rdata,
  output logic [DATA_W-1:0]     dma_wdata,
  output logic                  dma_wvalid,
  input  logic                  dma_wready,
  input  logic [DATA_W-1:0]     dma_rdata,
  input  logic                  dma_rvalid,
  output logic                  dma_rready,
  output logic                  busy,
  output logic                  err_pulse,
  output logic [15:0]           err_count
);

  typedef enum logic [1:0] {CLS_CSR, CLS_DMA, CLS_UNMAP}  cls_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP}       w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_CSR, R_DMA, R_ERR}  r_state_t;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // CSR wins if both would match (only possible with DMA_TAG == 0).
  function automatic cls_t decode(input logic [ADDR_W-1:0] a);
    cls_t c;
    if (a[ADDR_W-1:CSR_AW] == '0)          c = CLS_CSR;
    else if (a[ADDR_W-1 -: 4] == DMA_TAG)  c = CLS_DMA;
    else                                   c = CLS_UNMAP;
    return c;
  endfunction

  // Transfer size is not used: every beat is treated as a full-width word.
  logic unused;
  assign unused = ^{s_axi_awsize, s_axi_arsize};

  // ---------------------------------------------------------------- write
  w_state_t          w_state, w_next;
  logic [CSR_AW-1:0] aw_addr_q;
  logic [7:0]        aw_len_q;
  cls_t              aw_cls_q, aw_cls;
  logic [7:0]        w_beat_q;
  logic              w_slverr_q;
  logic              awready_i, wready_i, bvalid_i;
  logic              aw_hs, w_hs, b_hs, w_final, beat_err, strb_full;
  logic [1:0]        bresp_i;

  assign aw_cls    = decode(s_axi_awaddr);
  assign strb_full = &s_axi_wstrb;
  assign w_final   = (w_beat_q == aw_len_q);
  // Burst length is counter-driven; a wlast that disagrees with the counter
  // only taints the response.
  assign beat_err  = ((aw_cls_q == CLS_DMA) && !strb_full) || (s_axi_wlast != w_final);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    w_next    = w_state;
    awready_i = 1'b0;
    wready_i  = 1'b0;
    bvalid_i  = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        awready_i = 1'b1;
        if (s_axi_awvalid) w_next = W_DATA;
      end
      W_DATA: begin
        wready_i = (aw_cls_q == CLS_DMA) ? dma_wready : 1'b1;
        if (s_axi_wvalid && wready_i && w_final) w_next = W_RESP;
      end
      W_RESP: begin
        bvalid_i = 1'b1;
        if (s_axi_bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  assign aw_hs   = s_axi_awvalid && awready_i;
  assign w_hs    = s_axi_wvalid && wready_i;
  assign b_hs    = bvalid_i && s_axi_bready;
  assign bresp_i = (aw_cls_q == CLS_UNMAP) ? RESP_DECERR :
                   w_slverr_q              ? RESP_SLVERR : RESP_OKAY;

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
      w_state    <= W_IDLE;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_cls_q   <= CLS_CSR;
      w_beat_q   <= '0;
      w_slverr_q <= 1'b0;
    end else begin
      w_state <= w_next;
      if (aw_hs) begin
        aw_addr_q  <= s_axi_awaddr[CSR_AW-1:0];
        aw_len_q   <= s_axi_awlen;
        aw_cls_q   <= aw_cls;
        w_beat_q   <= '0;
        w_slverr_q <= (s_axi_awburst != BURST_INCR) ||
                      ((aw_cls == CLS_CSR) && (s_axi_awlen != 8'd0));
      end else if (w_hs) begin
        w_beat_q <= w_beat_q + 8'd1;
        if (beat_err) w_slverr_q <= 1'b1;
      end
    end
  end

  // ----------------------------------------------------------------- read
  r_state_t          r_state, r_next;
  logic [CSR_AW-1:0] ar_addr_q;
  logic [7:0]        ar_len_q;
  logic [7:0]        r_beat_q;
  logic              ar_burst_bad_q, ar_unmap_q;
  logic [1:0]        csr_ph_q;   // 0: strobe ren, 1: capture rdata, 2: present beat
  logic [DATA_W-1:0] csr_data_q;
  cls_t              ar_cls;
  logic              arready_i, rvalid_i, rlast_i, dma_rready_i, csr_ren_i;
  logic [DATA_W-1:0] rdata_i;
  logic [1:0]        rresp_i;
  logic              ar_hs, r_hs, r_final;

  assign ar_cls  = decode(s_axi_araddr);
  assign r_final = (r_beat_q == ar_len_q);

  always_comb begin
    r_next       = r_state;
    arready_i    = 1'b0;
    rvalid_i     = 1'b0;
    rlast_i      = 1'b0;
    rdata_i      = '0;
    rresp_i      = RESP_OKAY;
    dma_rready_i = 1'b0;
    csr_ren_i    = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        arready_i = 1'b1;
        if (s_axi_arvalid) begin
          if ((ar_cls == CLS_CSR) && (s_axi_arlen == 8'd0)) r_next = R_CSR;
          else if (ar_cls == CLS_DMA)                        r_next = R_DMA;
          else                                               r_next = R_ERR;
        end
      end
      R_CSR: begin
        csr_ren_i = (csr_ph_q == 2'd0);
        if (csr_ph_q == 2'd2) begin
          rvalid_i = 1'b1;
          rlast_i  = 1'b1;
          rdata_i  = csr_data_q;
        end
      end
      R_DMA: begin
        rvalid_i     = dma_rvalid;
        rdata_i      = dma_rdata;
        dma_rready_i = s_axi_rready;
        rlast_i      = r_final;
        rresp_i      = ar_burst_bad_q ? RESP_SLVERR : RESP_OKAY;
      end
      R_ERR: begin
        rvalid_i = 1'b1;
        rlast_i  = r_final;
        rresp_i  = ar_unmap_q ? RESP_DECERR : RESP_SLVERR;
      end
      default: r_next = R_IDLE;
    endcase
    if ((r_state != R_IDLE) && rvalid_i && s_axi_rready && rlast_i) r_next = R_IDLE;
  end

  assign ar_hs = s_axi_arvalid && arready_i;
  assign r_hs  = rvalid_i && s_axi_rready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= R_IDLE;
      ar_addr_q      <= '0;
      ar_len_q       <= '0;
      r_beat_q       <= '0;
      ar_burst_bad_q <= 1'b0;
      ar_unmap_q     <= 1'b0;
      csr_ph_q       <= '0;
      csr_data_q     <= '0;
    end else begin
      r_state <= r_next;
      if (ar_hs) begin
        ar_addr_q      <= s_axi_araddr[CSR_AW-1:0];
        ar_len_q       <= s_axi_arlen;
        r_beat_q       <= '0;
        ar_burst_bad_q <= (s_axi_arburst != BURST_INCR);
        ar_unmap_q     <= (ar_cls == CLS_UNMAP);
        csr_ph_q       <= '0;
      end else begin
        if (r_hs) r_beat_q <= r_beat_q + 8'd1;
        if ((r_state == R_CSR) && (csr_ph_q != 2'd2)) csr_ph_q <= csr_ph_q + 2'd1;
        if ((r_state == R_CSR) && (csr_ph_q == 2'd1)) csr_data_q <= csr_rdata;
      end
    end
  end

  // --------------------------------------------------------------- errors
  logic        w_err_ev, r_err_ev;
  logic [1:0]  err_inc;
  logic [16:0] err_sum;
  logic [15:0] err_cnt_q;

  assign w_err_ev = b_hs && (bresp_i != RESP_OKAY);
  assign r_err_ev = r_hs && rlast_i && (rresp_i != RESP_OKAY);
  assign err_inc  = {1'b0, w_err_ev} + {1'b0, r_err_ev};
  assign err_sum  = {1'b0, err_cnt_q} + {15'd0, err_inc};

  always_ff @(posedge clk) begin
    if (rst)            err_cnt_q <= '0;
    else if (err_sum[16]) err_cnt_q <= 16'hFFFF;
    else                err_cnt_q <= err_sum[15:0];
  end

  // ------------------------------------------------------------- outputs
  // Every output is forced low while rst is high, including the cycle in
  // which reset is first sampled and the registers still hold old state.
  assign s_axi_awready = awready_i & ~rst;
  assign s_axi_wready  = wready_i & ~rst;
  assign s_axi_bvalid  = bvalid_i & ~rst;
  assign s_axi_bresp   = rst ? 2'b00 : (bvalid_i ? bresp_i : RESP_OKAY);
  assign s_axi_arready = arready_i & ~rst;
  assign s_axi_rvalid  = rvalid_i & ~rst;
  assign s_axi_rlast   = rlast_i & ~rst;
  assign s_axi_rresp   = rst ? 2'b00 : rresp_i;
  assign s_axi_rdata   = rst ? '0 : rdata_i;

  assign csr_wen   = ~rst & w_hs & (aw_cls_q == CLS_CSR) & (aw_len_q == 8'd0);
  assign csr_waddr = rst ? '0 : aw_addr_q;
  assign csr_wdata = rst ? '0 : s_axi_wdata;
  assign csr_wstrb = rst ? '0 : s_axi_wstrb;
  assign csr_ren   = csr_ren_i & ~rst;
  assign csr_raddr = rst ? '0 : ar_addr_q;

  // Beats with partial strobes are never handed to the DMA FIFO.
  assign dma_wvalid = ~rst & s_axi_wvalid & (w_state == W_DATA) & (aw_cls_q == CLS_DMA) & strb_full;
  assign dma_wdata  = rst ? '0 : s_axi_wdata;
  assign dma_rready = dma_rready_i & ~rst;

  assign busy      = ~rst & ~((w_state == W_IDLE) && (r_state == R_IDLE));
  assign err_pulse = ~rst & (w_err_ev | r_err_ev);
  assign err_count = rst ? 16'd0 : err_cnt_q;

endmodule

// File: tb/tb_axi_burst_slave.sv
// Self-checking bench for axi_burst_slave: directed scenarios followed by
// randomized transactions, all compared against a reference model computed
// from the address-map and response rules.
module tb_axi_burst_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_axi_awaddr;
  logic [1:0]  s_axi_awburst;
  logic [7:0]  s_axi_awlen;
  logic [2:0]  s_axi_awsize;
  logic        s_axi_awvalid, s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid, s_axi_bready;
  logic [31:0] s_axi_araddr;
  logic [1:0]  s_axi_arburst;
  logic [7:0]  s_axi_arlen;
  logic [2:0]  s_axi_arsize;
  logic        s_axi_arvalid, s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;
  logic        csr_wen;
  logic [7:0]  csr_waddr;
  logic [31:0] csr_wdata;
  logic [3:0]  csr_wstrb;
  logic        csr_ren;
  logic [7:0]  csr_raddr;
  logic [31:0] csr_rdata;
  logic [31:0] dma_wdata;
  logic        dma_wvalid, dma_wready;
  logic [31:0] dma_rdata;
  logic        dma_rvalid, dma_rready;
  logic        busy, err_pulse;
  logic [15:0] err_count;

  int vectors     = 0;
  int miscompares = 0;
  int exp_err     = 0;

  axi_burst_slave dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awburst(s_axi_awburst), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arburst(s_axi_arburst), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .csr_wstrb(csr_wstrb),
    .csr_ren(csr_ren), .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .dma_wdata(dma_wdata), .dma_wvalid(dma_wvalid), .dma_wready(dma_wready),
    .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid), .dma_rready(dma_rready),
    .busy(busy), .err_pulse(err_pulse), .err_count(err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Address map: 0 = CSR (below 256), 1 = DMA (top nibble 1), 2 = unmapped.
  function automatic int classify(input logic [31:0] a);
    if (a < 32'd256) return 0;
    if ((a >> 28) == 32'd1) return 1;
    return 2;
  endfunction

  task automatic note_err(input int n);
    exp_err = (exp_err + n > 65535) ? 65535 : exp_err + n;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [1:0] burst, input int len,
                           input bit fixed, input logic [31:0] base, input int bad_pct,
                           input int gap_pct, input int stall_pct, input int stall_beat,
                           input int stall_cycles);
    int cls, beat, cyc, stalled, hold;
    bit slv, hs, bad_strb, last_ok, exp_wr;
    logic [1:0] exp_resp;
    cls = classify(addr);
    slv = (burst != 2'b01) || (cls == 0 && len != 0);
    @(negedge clk);
    s_axi_awaddr = addr; s_axi_awburst = burst; s_axi_awlen = 8'(len);
    s_axi_awsize = 3'd2; s_axi_awvalid = 1'b1;
    #1 check("awready", s_axi_awready, 1);
    @(posedge clk);
    @(negedge clk);
    s_axi_awvalid = 1'b0;
    beat = 0; cyc = 0; stalled = 0;
    while (beat <= len && cyc < 400) begin
      s_axi_wvalid = ($urandom_range(0, 99) >= gap_pct);
      s_axi_wdata  = fixed ? base + 32'(beat) : $urandom;
      bad_strb     = ($urandom_range(0, 99) < bad_pct);
      s_axi_wstrb  = bad_strb ? 4'($urandom_range(0, 14)) : 4'hF;
      last_ok      = ($urandom_range(0, 99) >= bad_pct);
      s_axi_wlast  = last_ok ? (beat == len) : (beat != len);
      if (beat == stall_beat && stalled < stall_cycles) begin
        dma_wready = 1'b0;
        stalled++;
      end else begin
        dma_wready = ($urandom_range(0, 99) >= stall_pct);
      end
      #1;
      exp_wr = (cls == 1) ? dma_wready : 1'b1;
      hs = s_axi_wvalid && exp_wr;
      check("wready", s_axi_wready, exp_wr);
      check("bvalid_early", s_axi_bvalid, 0);
      check("csr_wen", csr_wen, hs && cls == 0 && len == 0);
      if (hs && cls == 0 && len == 0) begin
        check("csr_waddr", csr_waddr, addr & 32'hFF);
        check("csr_wdata", csr_wdata, s_axi_wdata);
        check("csr_wstrb", csr_wstrb, s_axi_wstrb);
      end
      check("dma_wvalid", dma_wvalid, s_axi_wvalid && cls == 1 && !bad_strb);
      if (s_axi_wvalid && cls == 1 && !bad_strb) check("dma_wdata", dma_wdata, s_axi_wdata);
      if (hs) begin
        if (cls == 1 && bad_strb) slv = 1'b1;
        if (!last_ok) slv = 1'b1;
        beat++;
      end
      @(negedge clk);
      cyc++;
    end
    check("w_beats", beat, len + 1);
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; dma_wready = 1'b0;
    exp_resp = (cls == 2) ? 2'b11 : slv ? 2'b10 : 2'b00;
    hold = $urandom_range(0, 3);
    #1;
    check("bvalid_first", s_axi_bvalid, 1);
    check("bresp", s_axi_bresp, exp_resp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk); #1;
      check("bvalid_hold", s_axi_bvalid, 1);
      check("bresp_hold", s_axi_bresp, exp_resp);
    end
    @(negedge clk);
    s_axi_bready = 1'b1;
    #1;
    check("bvalid_hs", s_axi_bvalid, 1);
    check("err_pulse_b", err_pulse, exp_resp != 2'b00);
    @(negedge clk);
    s_axi_bready = 1'b0;
    if (exp_resp != 2'b00) note_err(1);
    #1;
    check("err_count_w", err_count, exp_err);
    check("awready_back", s_axi_awready, 1);
    check("busy_idle_w", busy, 0);
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [1:0] burst, input int len,
                          input logic [31:0] csr_val, input int gap_pct, input int hold_max);
    int cls, beat, cyc, hold;
    bit hs, fin, exp_rv;
    logic [1:0] exp_resp;
    cls = classify(addr);
    @(negedge clk);
    s_axi_araddr = addr; s_axi_arburst = burst; s_axi_arlen = 8'(len);
    s_axi_arsize = 3'd2; s_axi_arvalid = 1'b1;
    #1 check("arready", s_axi_arready, 1);
    @(posedge clk);
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    if (cls == 0 && len == 0) begin
      #1;
      check("csr_ren", csr_ren, 1);
      check("csr_raddr", csr_raddr, addr & 32'hFF);
      check("rvalid_early", s_axi_rvalid, 0);
      @(negedge clk);
      csr_rdata = csr_val;
      #1;
      check("csr_ren_once", csr_ren, 0);
      @(negedge clk);
      csr_rdata = $urandom;
      hold = $urandom_range(0, hold_max);
      #1;
      check("rvalid_csr", s_axi_rvalid, 1);
      check("rdata_csr", s_axi_rdata, csr_val);
      check("rlast_csr", s_axi_rlast, 1);
      check("rresp_csr", s_axi_rresp, 0);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk); #1;
        check("rvalid_csr_hold", s_axi_rvalid, 1);
        check("rdata_csr_hold", s_axi_rdata, csr_val);
      end
      @(negedge clk);
      s_axi_rready = 1'b1;
      #1 check("err_pulse_rcsr", err_pulse, 0);
      @(negedge clk);
      s_axi_rready = 1'b0;
      #1;
      check("rvalid_done", s_axi_rvalid, 0);
      check("arready_back", s_axi_arready, 1);
    end else begin
      exp_resp = (cls == 1) ? ((burst != 2'b01) ? 2'b10 : 2'b00) : (cls == 2) ? 2'b11 : 2'b10;
      beat = 0; cyc = 0;
      while (beat <= len && cyc < 400) begin
        dma_rvalid   = ($urandom_range(0, 99) >= gap_pct);
        dma_rdata    = $urandom;
        s_axi_rready = ($urandom_range(0, 99) >= gap_pct);
        #1;
        exp_rv = (cls == 1) ? dma_rvalid : 1'b1;
        check("rvalid", s_axi_rvalid, exp_rv);
        check("dma_rready", dma_rready, (cls == 1) ? s_axi_rready : 1'b0);
        if (exp_rv) begin
          check("rdata", s_axi_rdata, (cls == 1) ? dma_rdata : 32'd0);
          check("rlast", s_axi_rlast, beat == len);
          check("rresp", s_axi_rresp, exp_resp);
        end
        hs  = exp_rv && s_axi_rready;
        fin = hs && (beat == len);
        check("err_pulse_r", err_pulse, fin && exp_resp != 2'b00);
        if (hs) beat++;
        if (fin && exp_resp != 2'b00) note_err(1);
        @(negedge clk);
        cyc++;
      end
      s_axi_rready = 1'b0; dma_rvalid = 1'b0;
      check("r_beats", beat, len + 1);
      #1;
      check("err_count_r", err_count, exp_err);
      check("arready_back", s_axi_arready, 1);
      check("rvalid_done", s_axi_rvalid, 0);
    end
  endtask

  initial begin
    int kind, len;
    logic [31:0] addr;
    logic [1:0]  burst;
    rst = 1'b1;
    s_axi_awaddr = '0; s_axi_awburst = 2'b01; s_axi_awlen = '0; s_axi_awsize = 3'd2; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    s_axi_araddr = '0; s_axi_arburst = 2'b01; s_axi_arlen = '0; s_axi_arsize = 3'd2; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0; csr_rdata = '0; dma_wready = 1'b0; dma_rdata = '0; dma_rvalid = 1'b0;

    // Reset state: everything low while rst is high, ready right after.
    @(negedge clk); @(negedge clk); #1;
    check("rst_awready", s_axi_awready, 0);
    check("rst_arready", s_axi_arready, 0);
    check("rst_busy", busy, 0);
    check("rst_err_count", err_count, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_awready", s_axi_awready, 1);
    check("post_rst_arready", s_axi_arready, 1);
    check("post_rst_busy", busy, 0);

    // Directed scenarios.
    axi_write(32'h51, 2'b01, 0, 1'b1, 32'h1, 0, 0, 0, -1, 0);
    axi_read(32'h53, 2'b01, 0, 32'hA5A5_0003, 0, 2);
    axi_write(32'hFF00, 2'b01, 0, 1'b1, 32'h0, 0, 0, 0, -1, 0);
    axi_write(32'h1000_0000, 2'b01, 3, 1'b1, 32'hDEAD_0000, 0, 0, 0, 1, 3);
    axi_read(32'h1000_0000, 2'b01, 3, 32'h0, 40, 0);
    axi_write(32'h10, 2'b01, 2, 1'b0, 32'h0, 0, 0, 0, -1, 0);
    axi_read(32'h20, 2'b01, 1, 32'h0, 0, 0);

    // Simultaneous AW/AR acceptance; both channels erroring in one cycle.
    @(negedge clk);
    s_axi_awaddr = 32'hFF00; s_axi_awburst = 2'b01; s_axi_awlen = 8'd0; s_axi_awvalid = 1'b1;
    s_axi_araddr = 32'h2000_0000; s_axi_arburst = 2'b01; s_axi_arlen = 8'd0; s_axi_arvalid = 1'b1;
    #1;
    check("dual_awready", s_axi_awready, 1);
    check("dual_arready", s_axi_arready, 1);
    @(negedge clk);
    s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
    s_axi_wvalid = 1'b1; s_axi_wdata = 32'h1234; s_axi_wstrb = 4'hF; s_axi_wlast = 1'b1;
    #1;
    check("dual_rvalid", s_axi_rvalid, 1);
    check("dual_rresp", s_axi_rresp, 2'b11);
    check("dual_rlast", s_axi_rlast, 1);
    check("dual_wready", s_axi_wready, 1);
    check("dual_busy", busy, 1);
    @(negedge clk);
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    #1;
    check("dual_bvalid", s_axi_bvalid, 1);
    check("dual_bresp", s_axi_bresp, 2'b11);
    @(negedge clk);
    s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    #1 check("dual_err_pulse", err_pulse, 1);
    @(negedge clk);
    s_axi_bready = 1'b0; s_axi_rready = 1'b0;
    note_err(2);
    #1;
    check("dual_err_count", err_count, exp_err);
    check("dual_busy_idle", busy, 0);

    // Reset in the middle of a DMA burst.
    @(negedge clk);
    s_axi_awaddr = 32'h1000_0000; s_axi_awburst = 2'b01; s_axi_awlen = 8'd3; s_axi_awvalid = 1'b1;
    #1 check("mid_awready", s_axi_awready, 1);
    @(negedge clk);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b1; s_axi_wstrb = 4'hF; s_axi_wlast = 1'b0;
    s_axi_wdata = 32'hBEEF_0000; dma_wready = 1'b1;
    #1;
    check("mid_fwd0", dma_wvalid, 1);
    check("mid_fwd0_data", dma_wdata, 32'hBEEF_0000);
    @(negedge clk);
    s_axi_wdata = 32'hBEEF_0001;
    #1 check("mid_fwd1", dma_wvalid, 1);
    @(negedge clk);
    rst = 1'b1; s_axi_wdata = 32'hBEEF_0002; s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    #1;
    check("in_rst_awready", s_axi_awready, 0);
    check("in_rst_arready", s_axi_arready, 0);
    check("in_rst_wready", s_axi_wready, 0);
    check("in_rst_dma_wvalid", dma_wvalid, 0);
    check("in_rst_busy", busy, 0);
    check("in_rst_bvalid", s_axi_bvalid, 0);
    check("in_rst_err_count", err_count, 0);
    @(negedge clk); #1;
    check("in_rst2_wready", s_axi_wready, 0);
    @(negedge clk);
    rst = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_rready = 1'b0; dma_wready = 1'b0;
    exp_err = 0;
    #1;
    check("after_rst_awready", s_axi_awready, 1);
    check("after_rst_bvalid", s_axi_bvalid, 0);
    check("after_rst_busy", busy, 0);
    axi_write(32'h40, 2'b01, 0, 1'b1, 32'h77, 0, 0, 0, -1, 0);

    // Randomized transactions against the model.
    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 2);
      case (kind)
        0:       addr = 32'($urandom_range(0, 255));
        1:       addr = {4'h1, 28'($urandom)};
        default: addr = {4'($urandom_range(2, 15)), 28'($urandom)};
      endcase
      burst = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
      len   = (kind == 0 && $urandom_range(0, 3) != 0) ? 0 : int'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1)
        axi_write(addr, burst, len, 1'b0, 32'h0, 10, 20, 30, -1, 0);
      else
        axi_read(addr, burst, len, $urandom, 30, 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_burst_slave.md
AXI_BURST_SLAVE -- requirements
Module: axi_burst_slave

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DATA_W, 32, AXI/stream data width; legal values 32, 64, 128.
- ADDR_W, 32, AXI address width.
- CSR_AW, 8, CSR window is byte addresses 0 .. 2^CSR_AW-1.
- DMA_TAG, 4'h1, addr[ADDR_W-1:ADDR_W-4]==DMA_TAG selects the DMA window.
REQ-002 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-003 Ports (name, direction, width, meaning), one per line, clock and reset first:
- clk  in  1  sole clock.
- rst  in  1  synchronous active-high reset.
- s_axi_aw{addr,burst,len,size,valid}  in  ADDR_W,2,8,3,1  write address channel.
- s_axi_awready  out  1  write address ready.
- s_axi_w{data,strb,last,valid}  in  DATA_W,DATA_W/8,1,1  write data channel.
- s_axi_wready  out  1  write data ready.
- s_axi_bresp, s_axi_bvalid  out  2,1  write response.
- s_axi_bready  in  1  response accept.
- s_axi_ar{addr,burst,len,size,valid}  in  ADDR_W,2,8,3,1  read address channel.
- s_axi_arready  out  1  read address ready.
- s_axi_r{data,resp,last,valid}  out  DATA_W,2,1,1  read data channel.
- s_axi_rready  in  1  read data accept.
- csr_wen, csr_waddr, csr_wdata, csr_wstrb  out  1,CSR_AW,DATA_W,DATA_W/8  CSR write strobe.
- csr_ren, csr_raddr  out  1,CSR_AW  CSR read strobe.
- csr_rdata  in  DATA_W  valid one cycle after csr_ren.
- dma_wdata, dma_wvalid  out  DATA_W,1  stream to DMA input FIFO.
- dma_wready  in  1  DMA FIFO not full.
- dma_rdata, dma_rvalid  in  DATA_W,1  stream from result FIFO.
- dma_rready  out  1  result FIFO pop.
- busy  out  1  either FSM not idle.
- err_pulse  out  1  one-cycle pulse per error response.
- err_count  out  16  saturating count of error responses.

Function
REQ-004 Decode each AW/AR address into exactly one class:
- CSR: upper ADDR_W-CSR_AW bits all zero.
- DMA: top nibble equals DMA_TAG.
- UNMAPPED: neither.
REQ-005 Write FSM states SHALL be W_IDLE -> W_DATA -> W_RESP -> W_IDLE; s_axi_awready=1 only in W_IDLE; the AW handshake latches addr, len, class and clears the beat counter.
REQ-006 In W_DATA, s_axi_wready: CSR and UNMAPPED classes 1; DMA class equals dma_wready; dma_wvalid=s_axi_wvalid&&W_DATA&&DMA, combinational (zero-latency pass-through).
REQ-007 W_DATA SHALL exit to W_RESP on the handshake of beat number awlen (counter-based, independent of wlast).
REQ-008 CSR write: csr_wen pulses on the same cycle as the W handshake, with csr_waddr = awaddr[CSR_AW-1:0] and wdata/wstrb forwarded.
REQ-009 BRESP priority SHALL be:
- DECERR 2'b11 for UNMAPPED.
- Else SLVERR 2'b10 for any of: CSR with awlen!=0 (no csr_wen issued for any beat); awburst!=INCR; a DMA beat with wstrb not all ones (that beat not forwarded); wlast value mismatching beat==awlen on any beat.
- Else OKAY 2'b00.
REQ-010 s_axi_bvalid SHALL assert in the first W_RESP cycle and hold, bresp stable, until bready; return to W_IDLE the cycle after the handshake.
REQ-011 Read FSM states SHALL be R_IDLE -> R_CSR/R_DMA/R_ERR -> R_IDLE; s_axi_arready=1 only in R_IDLE.
REQ-012 R_CSR (arlen==0): csr_ren pulses the cycle after the AR handshake; rdata registered from csr_rdata on the following cycle; rvalid=1, rlast=1, rresp=OKAY, held until rready.
REQ-013 R_DMA: s_axi_rvalid=dma_rvalid, s_axi_rdata=dma_rdata, dma_rready=s_axi_rready, combinational; rlast=1 on beat arlen; exit to R_IDLE on that beat's handshake; rresp OKAY, or SLVERR if arburst!=INCR (data still returned).
REQ-014 R_ERR (UNMAPPED, or CSR with arlen!=0): return arlen+1 beats, rdata=0, rvalid=1 every cycle, rresp DECERR/SLVERR per REQ-009 rules, rlast on final beat.
REQ-015 Read and write FSMs SHALL be independent; simultaneous AW and AR handshakes in one cycle are both accepted; simultaneous csr_wen and csr_ren are permitted.
REQ-016 err_pulse fires on each B or final-R handshake carrying non-OKAY; err_count increments by one per such pulse, saturating at 16'hFFFF; both channels erroring in one cycle increment by 2 (saturating).
REQ-017 busy = !(W_IDLE && R_IDLE).

Reset
REQ-018 While rst=1 all outputs SHALL be 0, including awready and arready; FSMs return to IDLE and counters clear.
REQ-019 awready and arready SHALL be 1 in the first cycle after rst falls.
REQ-020 Reset mid-burst SHALL abort with no B/R response issued; partial DMA beats already forwarded are not retracted.

Verification
REQ-021 CSR write awaddr=0x51, awlen=0, wdata=0x1 -> csr_wen one cycle with csr_waddr=0x51, wdata=0x1; bresp=00.
REQ-022 CSR read araddr=0x53, csr_rdata=0xA5A5_0003 -> single beat rdata=0xA5A5_0003, rlast=1, rresp=00.
REQ-023 Write awaddr=0xFF00, awlen=0 -> no csr_wen, bresp=11, err_pulse once, err_count=1.
REQ-024 DMA burst awaddr=0x1000_0000, awlen=3, data 0xDEAD_0000+i, dma_wready low on beat 1 for 3 cycles -> wready low for those cycles; 4 beats delivered in order; bresp=00 only after beat 3.
REQ-025 DMA read arlen=3 with dma_rvalid gapped -> 4 beats, rlast only on beat 3, dma_rready mirrors rready.
REQ-026 rst asserted after 2 of 4 burst beats -> no bvalid; awready=1 the cycle after rst falls; a new 1-beat CSR write completes with bresp=00.
